ppu_row_sched: RTL and testbench

Per-scanline render scheduler for the PPU logic. Owns the ping-pong selection between the two row RAMs: the PPU engines write one while the HDMI video output reads the other. On each `rowram_swap` from the video output it flips the buffers, advances the row number, and sequences the render engines with start/done handshakes:

- background tile engine, foreground tile engine and sprite engine in parallel;
- then the pixel mixer.

It detects and counts render overruns.

---
 rtl/ppu_row_sched_if.sv | 35 +++
 rtl/ppu_row_sched.sv | 167 ++++++++++++++++
 tb/tb_ppu_row_sched.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_row_sched_if.sv
// ppu_row_sched_if: swap/done inputs and start/status outputs of the
// per-scanline render scheduler, bundled as one port.
interface ppu_row_sched_if #(
    parameter int ROW_W = 8
);
    logic             rowram_swap;
    logic             frame_start;
    logic             bg_done;
    logic             fg_done;
    logic             spr_done;
    logic             mix_done;
    logic             bg_start;
    logic             fg_start;
    logic             spr_start;
    logic             mix_start;
    logic             eng_abort;
    logic             rr_wr_sel;
    logic [ROW_W-1:0] row_num;
    logic             row_ready;
    logic [7:0]       overrun_cnt;

    // Video output / engines side
    modport master (
        output rowram_swap, frame_start, bg_done, fg_done, spr_done, mix_done,
        input  bg_start, fg_start, spr_start, mix_start, eng_abort,
               rr_wr_sel, row_num, row_ready, overrun_cnt
    );

    // Scheduler side
    modport slave (
        input  rowram_swap, frame_start, bg_done, fg_done, spr_done, mix_done,
        output bg_start, fg_start, spr_start, mix_start, eng_abort,
               rr_wr_sel, row_num, row_ready, overrun_cnt
    );
endinterface

// File: rtl/ppu_row_sched.sv
// ppu_row_sched: per-scanline render scheduler. Flips the row-RAM ping-pong
// on every swap, advances the row number, runs the three fetch engines in
// parallel and then the mixer, and aborts the engines on an overrun.
// Optional feature macro: PPU_OVERRUN_CNT_EN builds the saturating overrun
// counter; without it overrun_cnt is tied to zero.
module ppu_row_sched #(
    parameter int NUM_ROWS = 240,
    parameter int ROW_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    ppu_row_sched_if.slave     bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_FETCH,
        ST_MIX,
        ST_DONE,
        ST_ABORT
    } state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_bg_flag, r_fg_flag, r_spr_flag;
    logic             w_bg_flag_next, w_fg_flag_next, w_spr_flag_next;
    logic             r_fetch_start;
    logic             r_mix_start;
    logic             r_eng_abort;
    logic             r_rr_wr_sel;
    logic [ROW_W-1:0] r_row_num;
    logic [ROW_W-1:0] w_row_next;
    logic             r_row_ready;
    logic             w_swap;

    assign w_swap = bus.rowram_swap;

    // The new row after a swap: frame_start forces row 0, otherwise wrap at the last row
    always_comb begin
        w_row_next = r_row_num;
        if (bus.frame_start || r_row_num == LAST_ROW) begin
            w_row_next = '0;
        end else begin
            w_row_next = r_row_num + ROW_W'(1);
        end
    end

    // Next-state and sticky done flags; swap wins over dones except mix_done in MIX
    always_comb begin
        w_state_next    = r_state;
        w_bg_flag_next  = r_bg_flag;
        w_fg_flag_next  = r_fg_flag;
        w_spr_flag_next = r_spr_flag;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_swap) w_state_next = ST_START;
            end
            ST_START: begin
                // Flags restart from zero; dones arriving in the start cycle already count
                w_bg_flag_next  = bus.bg_done;
                w_fg_flag_next  = bus.fg_done;
                w_spr_flag_next = bus.spr_done;
                if (w_swap) begin
                    w_state_next = ST_ABORT;
                end else if (bus.bg_done && bus.fg_done && bus.spr_done) begin
                    w_state_next = ST_MIX;
                end else begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_bg_flag_next  = r_bg_flag  | bus.bg_done;
                w_fg_flag_next  = r_fg_flag  | bus.fg_done;
                w_spr_flag_next = r_spr_flag | bus.spr_done;
                if (w_swap) begin
                    w_state_next = ST_ABORT;
                end else if (w_bg_flag_next && w_fg_flag_next && w_spr_flag_next) begin
                    w_state_next = ST_MIX;
                end
            end
            ST_MIX: begin
                if (bus.mix_done) begin
                    w_state_next = w_swap ? ST_START : ST_DONE;
                end else if (w_swap) begin
                    w_state_next = ST_ABORT;
                end
            end
            ST_ABORT: begin
                w_state_next = ST_START;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State, flags and registered pulse outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bg_flag     <= 1'b0;
            r_fg_flag     <= 1'b0;
            r_spr_flag    <= 1'b0;
            r_fetch_start <= 1'b0;
            r_mix_start   <= 1'b0;
            r_eng_abort   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_bg_flag     <= w_bg_flag_next;
            r_fg_flag     <= w_fg_flag_next;
            r_spr_flag    <= w_spr_flag_next;
            r_fetch_start <= (w_state_next == ST_START);
            r_mix_start   <= (w_state_next == ST_MIX) && (r_state != ST_MIX);
            r_eng_abort   <= (w_state_next == ST_ABORT);
        end
    end

    // Buffer select, row number and row-ready status follow every swap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_wr_sel <= 1'b0;
            r_row_num   <= LAST_ROW;
            r_row_ready <= 1'b0;
        end else begin
            if (w_swap) begin
                r_rr_wr_sel <= ~r_rr_wr_sel;
                r_row_num   <= w_row_next;
                r_row_ready <= 1'b0;
            end else if (r_state == ST_MIX && bus.mix_done) begin
                r_row_ready <= 1'b1;
            end
        end
    end

`ifdef PPU_OVERRUN_CNT_EN
    logic [7:0] r_overrun_cnt;
    logic       w_overrun;

    // ABORT is only ever entered through an overrun
    assign w_overrun = (w_state_next == ST_ABORT);

    // Saturating overrun counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_overrun && r_overrun_cnt != 8'hFF) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign bus.overrun_cnt = r_overrun_cnt;
`else
    assign bus.overrun_cnt = 8'd0;
`endif

    assign bus.bg_start  = r_fetch_start;
    assign bus.fg_start  = r_fetch_start;
    assign bus.spr_start = r_fetch_start;
    assign bus.mix_start = r_mix_start;
    assign bus.eng_abort = r_eng_abort;
    assign bus.rr_wr_sel = r_rr_wr_sel;
    assign bus.row_num   = r_row_num;
    assign bus.row_ready = r_row_ready;

endmodule

// File: tb/tb_ppu_row_sched.sv
// tb_ppu_row_sched: scenario tasks drive swaps and done pulses; every swap
// pushes its expected row/select/abort/count into a scoreboard that a
// negedge monitor pops when the engines are started.
module tb_ppu_row_sched;
    localparam int NUM_ROWS = 240;
`ifdef PPU_OVERRUN_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] row;
        logic       sel;
        logic       abort;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [7:0] exp_row = 8'd239;
    logic       exp_sel = 1'b0;
    logic [7:0] exp_cnt = 8'd0;
    logic       prev_abort = 1'b0;

    always #5 clk = ~clk;

    ppu_row_sched_if #(.ROW_W(8)) bus ();

    ppu_row_sched #(.NUM_ROWS(NUM_ROWS), .ROW_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Scoreboard consumer: every abort and every start pulse must match a queued swap
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.eng_abort) begin
                checks++;
                if (sb_q.size() == 0 || !sb_q[0].abort || bus.bg_start !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_expected: eng_abort=%b bg_start=%b queued=%0d", bus.eng_abort, bus.bg_start, sb_q.size());
                end else if (bus.row_num !== sb_q[0].row || bus.rr_wr_sel !== sb_q[0].sel || bus.overrun_cnt !== sb_q[0].cnt) begin
                    failures++;
                    $display("FAIL abort_state: row=%0d sel=%b cnt=%0d required row=%0d sel=%b cnt=%0d",
                             bus.row_num, bus.rr_wr_sel, bus.overrun_cnt, sb_q[0].row, sb_q[0].sel, sb_q[0].cnt);
                end
            end
            if (bus.bg_start || bus.fg_start || bus.spr_start) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_start: bg=%b fg=%b spr=%b with no pending swap", bus.bg_start, bus.fg_start, bus.spr_start);
                end else begin
                    mon_e = sb_q.pop_front();
                    if ({bus.bg_start, bus.fg_start, bus.spr_start} !== 3'b111 || bus.row_num !== mon_e.row ||
                        bus.rr_wr_sel !== mon_e.sel || bus.overrun_cnt !== mon_e.cnt || prev_abort !== mon_e.abort) begin
                        failures++;
                        $display("FAIL start_state: starts=%b row=%0d sel=%b cnt=%0d prev_abort=%b required starts=111 row=%0d sel=%b cnt=%0d prev_abort=%b",
                                 {bus.bg_start, bus.fg_start, bus.spr_start}, bus.row_num, bus.rr_wr_sel, bus.overrun_cnt, prev_abort,
                                 mon_e.row, mon_e.sel, mon_e.cnt, mon_e.abort);
                    end
                end
            end
        end
        prev_abort = bus.eng_abort;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle swap pulse; queues what the block must show when it starts the row
    task automatic drive_swap(input logic fs, input logic ovr);
        exp_t e;
        if (fs || exp_row == 8'(NUM_ROWS - 1)) exp_row = 8'd0;
        else exp_row = exp_row + 8'd1;
        exp_sel = ~exp_sel;
        if (ovr && CNT_EN && exp_cnt != 8'd255) exp_cnt = exp_cnt + 8'd1;
        e.row = exp_row;
        e.sel = exp_sel;
        e.abort = ovr;
        e.cnt = exp_cnt;
        sb_q.push_back(e);
        bus.rowram_swap = 1'b1;
        bus.frame_start = fs;
        step();
        bus.rowram_swap = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    // Complete the current row from START or FETCH: all fetch dones, then mixer done
    task automatic finish_row();
        bus.bg_done = 1'b1; bus.fg_done = 1'b1; bus.spr_done = 1'b1;
        step();
        bus.bg_done = 1'b0; bus.fg_done = 1'b0; bus.spr_done = 1'b0;
        bus.mix_done = 1'b1;
        step();
        bus.mix_done = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        checks++;
        if (bus.row_num !== 8'd239 || bus.rr_wr_sel !== 1'b0 || bus.row_ready !== 1'b0 || bus.overrun_cnt !== 8'd0 ||
            {bus.bg_start, bus.fg_start, bus.spr_start, bus.mix_start, bus.eng_abort} !== 5'b0) begin
            failures++;
            $display("FAIL reset_values: row=%0d sel=%b ready=%b cnt=%0d pulses=%b required 239/0/0/0/00000",
                     bus.row_num, bus.rr_wr_sel, bus.row_ready, bus.overrun_cnt,
                     {bus.bg_start, bus.fg_start, bus.spr_start, bus.mix_start, bus.eng_abort});
        end
        rst_n = 1'b1;
        step();
        $display("test_reset done");
    endtask

    task automatic test_first_swap();
        drive_swap(1'b0, 1'b0);
        checks++;
        if (bus.row_num !== 8'd0 || bus.rr_wr_sel !== 1'b1 || {bus.bg_start, bus.fg_start, bus.spr_start} !== 3'b111) begin
            failures++;
            $display("FAIL first_swap: row=%0d sel=%b starts=%b required row=0 sel=1 starts=111",
                     bus.row_num, bus.rr_wr_sel, {bus.bg_start, bus.fg_start, bus.spr_start});
        end
        step();
        checks++;
        if ({bus.bg_start, bus.fg_start, bus.spr_start} !== 3'b000) begin
            failures++;
            $display("FAIL start_width: starts=%b required 000 one cycle later", {bus.bg_start, bus.fg_start, bus.spr_start});
        end
        finish_row();
        $display("test_first_swap done");
    endtask

    task automatic test_normal_row();
        drive_swap(1'b0, 1'b0);
        for (int i = 0; i <= 9; i++) begin
            bus.spr_done = (i == 3);
            bus.bg_done  = (i == 5);
            bus.fg_done  = (i == 9);
            step();
            checks++;
            if (bus.mix_start !== (i == 9)) begin
                failures++;
                $display("FAIL staggered_mix_start: cycle=%0d mix_start=%b required %b", i, bus.mix_start, (i == 9));
            end
        end
        bus.spr_done = 1'b0; bus.bg_done = 1'b0; bus.fg_done = 1'b0;
        bus.mix_done = 1'b1;
        step();
        bus.mix_done = 1'b0;
        checks++;
        if (bus.row_ready !== 1'b1 || bus.mix_start !== 1'b0) begin
            failures++;
            $display("FAIL row_ready_set: row_ready=%b mix_start=%b required 1/0", bus.row_ready, bus.mix_start);
        end
        step(); step(); step();
        checks++;
        if (bus.row_ready !== 1'b1) begin
            failures++;
            $display("FAIL row_ready_hold: row_ready=%b required 1", bus.row_ready);
        end
        $display("test_normal_row done");
    endtask

    task automatic test_frame_start_ignored();
        bus.frame_start = 1'b1;
        step(); step(); step();
        bus.frame_start = 1'b0;
        checks++;
        if (bus.row_num !== exp_row || bus.row_ready !== 1'b1) begin
            failures++;
            $display("FAIL lone_frame_start: row=%0d ready=%b required row=%0d ready=1", bus.row_num, bus.row_ready, exp_row);
        end
        drive_swap(1'b0, 1'b0);
        checks++;
        if (bus.row_ready !== 1'b0) begin
            failures++;
            $display("FAIL row_ready_clear: row_ready=%b required 0", bus.row_ready);
        end
        finish_row();
        $display("test_frame_start_ignored done");
    endtask

    task automatic test_wrap_and_frame_start();
        drive_swap(1'b1, 1'b0);
        finish_row();
        for (int r = 1; r < NUM_ROWS; r++) begin
            drive_swap(1'b0, 1'b0);
            finish_row();
        end
        drive_swap(1'b0, 1'b0);
        checks++;
        if (bus.row_num !== 8'd0) begin
            failures++;
            $display("FAIL row_wrap: row=%0d required 0", bus.row_num);
        end
        finish_row();
        while (exp_row != 8'd57) begin
            drive_swap(1'b0, 1'b0);
            finish_row();
        end
        drive_swap(1'b1, 1'b0);
        checks++;
        if (bus.row_num !== 8'd0) begin
            failures++;
            $display("FAIL frame_start_row57: row=%0d required 0", bus.row_num);
        end
        finish_row();
        $display("test_wrap_and_frame_start done");
    endtask

    task automatic test_simultaneous();
        drive_swap(1'b0, 1'b0);
        bus.bg_done = 1'b1; bus.fg_done = 1'b1; bus.spr_done = 1'b1;
        step();
        bus.bg_done = 1'b0; bus.fg_done = 1'b0; bus.spr_done = 1'b0;
        checks++;
        if (bus.mix_start !== 1'b1) begin
            failures++;
            $display("FAIL joint_dones_mix_start: mix_start=%b required 1", bus.mix_start);
        end
        step();
        checks++;
        if (bus.mix_start !== 1'b0) begin
            failures++;
            $display("FAIL single_mix_start: mix_start=%b required 0", bus.mix_start);
        end
        bus.mix_done = 1'b1;
        drive_swap(1'b0, 1'b0);
        bus.mix_done = 1'b0;
        checks++;
        if (bus.eng_abort !== 1'b0 || bus.bg_start !== 1'b1 || bus.overrun_cnt !== exp_cnt) begin
            failures++;
            $display("FAIL mix_done_with_swap: abort=%b bg_start=%b cnt=%0d required 0/1/%0d", bus.eng_abort, bus.bg_start, bus.overrun_cnt, exp_cnt);
        end
        step();
        bus.mix_done = 1'b1;
        step();
        bus.mix_done = 1'b0;
        checks++;
        if (bus.mix_start !== 1'b0 || bus.row_ready !== 1'b0) begin
            failures++;
            $display("FAIL stray_mix_done: mix_start=%b row_ready=%b required 0/0", bus.mix_start, bus.row_ready);
        end
        bus.bg_done = 1'b1; bus.fg_done = 1'b1; bus.spr_done = 1'b1;
        step();
        bus.bg_done = 1'b0; bus.fg_done = 1'b0; bus.spr_done = 1'b0;
        checks++;
        if (bus.mix_start !== 1'b1) begin
            failures++;
            $display("FAIL fetch_after_stray: mix_start=%b required 1", bus.mix_start);
        end
        step();
        checks++;
        if (bus.row_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_mix_done: row_ready=%b required 0", bus.row_ready);
        end
        bus.mix_done = 1'b1;
        step();
        bus.mix_done = 1'b0;
        checks++;
        if (bus.row_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_mix_done: row_ready=%b required 1", bus.row_ready);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_overrun();
        drive_swap(1'b0, 1'b0);
        step(); step();
        drive_swap(1'b0, 1'b1);
        checks++;
        if (bus.eng_abort !== 1'b1 || bus.bg_start !== 1'b0 || bus.row_num !== exp_row ||
            bus.overrun_cnt !== (CNT_EN ? 8'd1 : 8'd0)) begin
            failures++;
            $display("FAIL overrun_abort: abort=%b bg_start=%b row=%0d cnt=%0d required 1/0/%0d/%0d",
                     bus.eng_abort, bus.bg_start, bus.row_num, bus.overrun_cnt, exp_row, (CNT_EN ? 1 : 0));
        end
        step();
        checks++;
        if (bus.bg_start !== 1'b1 || bus.eng_abort !== 1'b0) begin
            failures++;
            $display("FAIL overrun_restart: bg_start=%b abort=%b required 1/0", bus.bg_start, bus.eng_abort);
        end
        for (int k = 0; k < 300; k++) begin
            drive_swap(1'b0, 1'b1);
            step();
        end
        checks++;
        if (bus.overrun_cnt !== (CNT_EN ? 8'd255 : 8'd0)) begin
            failures++;
            $display("FAIL overrun_saturate: cnt=%0d required %0d", bus.overrun_cnt, (CNT_EN ? 255 : 0));
        end
        finish_row();
        $display("test_overrun done");
    endtask

    task automatic test_reset_mid_row();
        drive_swap(1'b0, 1'b0);
        bus.bg_done = 1'b1; bus.fg_done = 1'b1; bus.spr_done = 1'b1;
        step();
        bus.bg_done = 1'b0; bus.fg_done = 1'b0; bus.spr_done = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.row_num !== 8'd239 || bus.rr_wr_sel !== 1'b0 || bus.row_ready !== 1'b0 || bus.overrun_cnt !== 8'd0 ||
            {bus.bg_start, bus.fg_start, bus.spr_start, bus.mix_start, bus.eng_abort} !== 5'b0) begin
            failures++;
            $display("FAIL async_reset: row=%0d sel=%b ready=%b cnt=%0d pulses=%b required 239/0/0/0/00000",
                     bus.row_num, bus.rr_wr_sel, bus.row_ready, bus.overrun_cnt,
                     {bus.bg_start, bus.fg_start, bus.spr_start, bus.mix_start, bus.eng_abort});
        end
        exp_row = 8'd239;
        exp_sel = 1'b0;
        exp_cnt = 8'd0;
        step(); step();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.bg_start, bus.mix_start, bus.eng_abort} !== 3'b000) begin
                failures++;
                $display("FAIL post_reset_quiet: cycle=%0d bg/mix/abort=%b required 000", c, {bus.bg_start, bus.mix_start, bus.eng_abort});
            end
        end
        drive_swap(1'b0, 1'b0);
        checks++;
        if (bus.row_num !== 8'd0 || bus.rr_wr_sel !== 1'b1) begin
            failures++;
            $display("FAIL swap_after_reset: row=%0d sel=%b required 0/1", bus.row_num, bus.rr_wr_sel);
        end
        finish_row();
        $display("test_reset_mid_row done");
    endtask

    initial begin
        bus.rowram_swap = 1'b0;
        bus.frame_start = 1'b0;
        bus.bg_done = 1'b0;
        bus.fg_done = 1'b0;
        bus.spr_done = 1'b0;
        bus.mix_done = 1'b0;
        test_reset();
        test_first_swap();
        test_normal_row();
        test_frame_start_ignored();
        test_wrap_and_frame_start();
        test_simultaneous();
        test_overrun();
        test_reset_mid_row();
        step(); step();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: pending=%0d required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
